// File: rtl/xb_fifo_pkg.sv
// Shared types and constants for the read_32 source FIFO.
// Pure declarations: no latency, no backpressure.
package xb_fifo_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_EOF    = 2'd3
    } xb_state_e;

    localparam int XB_DATA_W = 32;
    localparam int XB_STAT_W = 16;

endpackage

// File: rtl/xillybus_read_32_fifo_if.sv
// Producer and core-side signals of the read_32 source FIFO.
// Wires only: latency and backpressure are defined by the FIFO behind the slave modport.
interface xillybus_read_32_fifo_if #(
    parameter int DEPTH_LOG2 = 9
);
    logic [xb_fifo_pkg::XB_DATA_W-1:0] src_data_w;
    logic                              src_wren_w;
    logic                              src_eof_w;
    logic                              src_full_w;
    logic                              src_almost_full_w;
    logic                              src_open_w;
    logic                              user_r_read_32_rden_w;
    logic                              user_r_read_32_open_w;
    logic [xb_fifo_pkg::XB_DATA_W-1:0] user_r_read_32_data_w;
    logic                              user_r_read_32_empty_w;
    logic                              user_r_read_32_eof_w;
    logic [DEPTH_LOG2:0]               fill_level_w;

    modport slave (
        input  src_data_w, src_wren_w, src_eof_w,
        input  user_r_read_32_rden_w, user_r_read_32_open_w,
        output src_full_w, src_almost_full_w, src_open_w,
        output user_r_read_32_data_w, user_r_read_32_empty_w, user_r_read_32_eof_w,
        output fill_level_w
    );

    modport master (
        output src_data_w, src_wren_w, src_eof_w,
        output user_r_read_32_rden_w, user_r_read_32_open_w,
        input  src_full_w, src_almost_full_w, src_open_w,
        input  user_r_read_32_data_w, user_r_read_32_empty_w, user_r_read_32_eof_w,
        input  fill_level_w
    );
endinterface

// File: rtl/xb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
// No backpressure; the read register holds its value when rd_en is low.
module xb_sdp_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_dat_q;
    logic [DW-1:0] rd_dat_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/xillybus_read_32_fifo.sv
// Non-FWFT source FIFO for Xillybus read_32 with EOF sequencing and flush on close; 1-cycle read latency.
// Producer is throttled by src_full_w; optional XB_RD_FIFO_STATS_EN adds overflow/underflow counters.
module xillybus_read_32_fifo
    import xb_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int AF_MARGIN  = 4
) (
    input  logic                   bus_clk_w,
    input  logic                   bus_rst_n_w,
    xillybus_read_32_fifo_if.slave bus
`ifdef XB_RD_FIFO_STATS_EN
    ,
    output logic [XB_STAT_W-1:0]   ovf_cnt_w,
    output logic [XB_STAT_W-1:0]   udf_cnt_w
`endif
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    xb_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [PW-1:0] fill;
    logic [PW-1:0] free;
    logic          wr_acc;
    logic          rd_acc;

    assign fill   = wr_ptr_q - rd_ptr_q;
    assign free   = DEPTH - fill;
    assign wr_acc = (state_q == ST_OPEN) && bus.src_wren_w && !full_q;
    assign rd_acc = bus.user_r_read_32_rden_w && !empty_q && (state_q != ST_CLOSED);

    always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
        if (!bus_rst_n_w) begin
            state_q <= ST_CLOSED;
        end else begin
            state_q <= state_d;
        end
    end

    // Close overrides everything so a host close always flushes, even mid-drain.
    always_comb begin
        state_d = state_q;
        if (!bus.user_r_read_32_open_w) begin
            state_d = ST_CLOSED;
        end else begin
            case (state_q)
                ST_CLOSED: state_d = ST_OPEN;
                ST_OPEN:   if (bus.src_eof_w) state_d = ST_DRAIN;
                ST_DRAIN:  if (fill == '0) state_d = ST_EOF;
                ST_EOF:    state_d = ST_EOF;
                default:   state_d = ST_CLOSED;
            endcase
        end
    end

    always_comb begin
        bus.src_open_w             = (state_q == ST_OPEN);
        bus.src_full_w             = full_q || (state_q != ST_OPEN);
        bus.src_almost_full_w      = (state_q != ST_OPEN) || (free <= PW'(AF_MARGIN));
        bus.user_r_read_32_eof_w   = (state_q == ST_EOF);
        bus.user_r_read_32_empty_w = empty_q;
        bus.fill_level_w           = fill;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_acc};
        if (state_d == ST_CLOSED) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d == {~rd_ptr_d[PW-1], rd_ptr_d[PW-2:0]});
    end

    always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
        if (!bus_rst_n_w) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    xb_sdp_ram #(
        .AW (DEPTH_LOG2),
        .DW (XB_DATA_W)
    ) u_ram (
        .clk     (bus_clk_w),
        .rst_n   (bus_rst_n_w),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_dat  (bus.src_data_w),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_dat  (bus.user_r_read_32_data_w)
    );

`ifdef XB_RD_FIFO_STATS_EN
    logic [XB_STAT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [XB_STAT_W-1:0] udf_cnt_q, udf_cnt_d;
    logic                 ovf_evt;
    logic                 udf_evt;

    assign ovf_evt = (state_q == ST_OPEN) && bus.src_wren_w && full_q;
    assign udf_evt = bus.user_r_read_32_rden_w && empty_q && (state_q != ST_CLOSED);

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (state_d == ST_CLOSED) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (ovf_evt && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
            if (udf_evt && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
        if (!bus_rst_n_w) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt_w = ovf_cnt_q;
    assign udf_cnt_w = udf_cnt_q;
`endif

endmodule

// File: tb/tb_xillybus_read_32_fifo.sv
// Scoreboard bench for xillybus_read_32_fifo at DEPTH_LOG2=4: driver pushes expected words, monitor pops on reads.
module tb_xillybus_read_32_fifo;
    import xb_fifo_pkg::*;

    localparam int DL2 = 4;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic opn = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] exp_q[$];
    xb_state_e   m_state = ST_CLOSED;
    int          m_cnt = 0;
    int          m_ovf = 0;
    int          m_udf = 0;
    logic        pend = 1'b0;

    xillybus_read_32_fifo_if #(.DEPTH_LOG2(DL2)) bus();

`ifdef XB_RD_FIFO_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;
`endif

    xillybus_read_32_fifo #(.DEPTH_LOG2(DL2), .AF_MARGIN(4)) dut (
        .bus_clk_w   (clk),
        .bus_rst_n_w (rst_n),
        .bus         (bus)
`ifdef XB_RD_FIFO_STATS_EN
        ,
        .ovf_cnt_w   (ovf_cnt),
        .udf_cnt_w   (udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("fill_level", 32'(bus.fill_level_w), 32'(m_cnt));
        chk("empty", 32'(bus.user_r_read_32_empty_w), 32'(m_cnt == 0));
        chk("src_full", 32'(bus.src_full_w), 32'((m_state != ST_OPEN) || (m_cnt == DEP)));
        chk("almost_full", 32'(bus.src_almost_full_w), 32'((m_state != ST_OPEN) || (DEP - m_cnt <= 4)));
        chk("src_open", 32'(bus.src_open_w), 32'(m_state == ST_OPEN));
        chk("eof", 32'(bus.user_r_read_32_eof_w), 32'(m_state == ST_EOF));
`ifdef XB_RD_FIFO_STATS_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("udf_cnt", 32'(udf_cnt), 32'(m_udf));
`endif
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and updates the model.
    task automatic step(input logic wr, input logic [31:0] d, input logic eo, input logic rd);
        logic      wok;
        logic      rok;
        xb_state_e ns;
        bus.src_wren_w            = wr;
        bus.src_data_w            = d;
        bus.src_eof_w             = eo;
        bus.user_r_read_32_rden_w = rd;
        bus.user_r_read_32_open_w = opn;
        wok = (m_state == ST_OPEN) && wr && (m_cnt < DEP);
        rok = rd && (m_cnt > 0) && (m_state != ST_CLOSED);
        ns = m_state;
        if (!opn) ns = ST_CLOSED;
        else begin
            case (m_state)
                ST_CLOSED: ns = ST_OPEN;
                ST_OPEN:   if (eo) ns = ST_DRAIN;
                ST_DRAIN:  if (m_cnt == 0) ns = ST_EOF;
                default:   ns = m_state;
            endcase
        end
        if ((m_state == ST_OPEN) && wr && (m_cnt == DEP) && m_ovf < 65535) m_ovf++;
        if (rd && (m_cnt == 0) && (m_state != ST_CLOSED) && m_udf < 65535) m_udf++;
        if (wok) exp_q.push_back(d);
        m_cnt = m_cnt + int'(wok) - int'(rok);
        if (ns == ST_CLOSED) begin
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            exp_q.delete();
        end
        m_state = ns;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Monitor: a read fires at the next edge when rden is high and empty is low.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_data: read with no expected word, got 0x%08h", bus.user_r_read_32_data_w);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", bus.user_r_read_32_data_w, e);
                end
            end
            pend = rst_n && bus.user_r_read_32_rden_w && !bus.user_r_read_32_empty_w;
        end
    end

    initial begin
        int wcnt;
        logic w;
        logic r;
        bus.src_wren_w            = 1'b0;
        bus.src_data_w            = '0;
        bus.src_eof_w             = 1'b0;
        bus.user_r_read_32_rden_w = 1'b0;
        bus.user_r_read_32_open_w = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.user_r_read_32_data_w, 32'h0);
        check_outputs();
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Fill to full, overflow, read back in order
        opn = 1'b1;
        step(0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) step(1, 32'(i), 0, 0);
        chk("full_after_16", 32'(bus.src_full_w), 32'h1);
        step(1, 32'h11, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("empty_after_drain", 32'(bus.user_r_read_32_empty_w), 32'h1);

        // Pointer wrap with interleaved traffic
        wcnt = 0;
        for (int i = 0; i < 150 && (wcnt < 40 || m_cnt > 0); i++) begin
            w = (wcnt < 40) && (i % 4 != 3);
            r = (i >= 6) && (i % 4 != 0);
            step(w, 32'h1000 + 32'(wcnt), 0, r);
            if (w) wcnt++;
        end
        chk("wrap_words", 32'(wcnt), 32'd40);
        step(0, 0, 0, 0);

        // Simultaneous read+write at full, then at empty
        for (int i = 0; i < 16; i++) step(1, 32'h2000 + 32'(i), 0, 0);
        step(1, 32'hDEAD, 0, 1);
        chk("fill_15", 32'(bus.fill_level_w), 32'd15);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 32'h0ABC, 0, 1);
        chk("empty_deassert", 32'(bus.user_r_read_32_empty_w), 32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Close mid-stream with 7 words stored
        for (int i = 0; i < 7; i++) step(1, 32'h3000 + 32'(i), 0, 0);
        opn = 1'b0;
        step(0, 0, 0, 0);
        chk("close_fill", 32'(bus.fill_level_w), 32'd0);
        chk("close_empty", 32'(bus.user_r_read_32_empty_w), 32'h1);
        opn = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Overflow / underflow counting
        for (int i = 0; i < 16; i++) step(1, 32'h4000 + 32'(i), 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h4F00, 0, 0);
`ifdef XB_RD_FIFO_STATS_EN
        chk("ovf_5", 32'(ovf_cnt), 32'd5);
`endif
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
`ifdef XB_RD_FIFO_STATS_EN
        chk("udf_3", 32'(udf_cnt), 32'd3);
`endif
        step(0, 0, 0, 0);
        opn = 1'b0;
        step(0, 0, 0, 0);
`ifdef XB_RD_FIFO_STATS_EN
        chk("ovf_clr", 32'(ovf_cnt), 32'd0);
        chk("udf_clr", 32'(udf_cnt), 32'd0);
`endif
        opn = 1'b1;
        step(0, 0, 0, 0);

        // EOF sequencing
        step(1, 32'h5001, 0, 0);
        step(1, 32'h5002, 0, 0);
        step(1, 32'h5003, 1, 0);
        step(1, 32'h5004, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("eof_set", 32'(bus.user_r_read_32_eof_w), 32'h1);
        chk("eof_empty", 32'(bus.user_r_read_32_empty_w), 32'h1);
        opn = 1'b0;
        step(0, 0, 0, 0);
        chk("eof_clr", 32'(bus.user_r_read_32_eof_w), 32'h0);
        opn = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        @(negedge clk);
        chk("leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xillybus_read_32_fifo.md
# xillybus_read_32_fifo

Buffered source stage for the Xillybus `read_32` stream (FPGA→host). It accepts 32-bit words from application logic and presents them to the core's `user_r_read_32_*` port with standard (non-FWFT) FIFO semantics. It also converts a producer end-of-stream request into a correctly timed EOF indication, and flushes itself whenever the host closes the device file.

## Interface
- `DEPTH_LOG2`, default 9: storage depth is 2^DEPTH_LOG2 words.
- `AF_MARGIN`, default 4: `src_almost_full_w` asserts when free space ≤ AF_MARGIN.
- `bus_clk_w`, in, 1: single clock. All logic runs on this clock.
- `bus_rst_n_w`, in, 1: reset, asynchronous assert, active-low.
- `src_data_w`, in, 32: producer word.
- `src_wren_w`, in, 1: producer write strobe.
- `src_eof_w`, in, 1: end-of-stream request. A word written in the same cycle is the last word.
- `src_full_w`, out, 1: write will be rejected.
- `src_almost_full_w`, out, 1: free space ≤ AF_MARGIN.
- `src_open_w`, out, 1: stream is accepting data (state OPEN).
- `user_r_read_32_rden_w`, in, 1: core read strobe.
- `user_r_read_32_open_w`, in, 1: host has the file open.
- `user_r_read_32_data_w`, out, 32: read data, registered.
- `user_r_read_32_empty_w`, out, 1: no word available.
- `user_r_read_32_eof_w`, out, 1: end of stream.
- `fill_level_w`, out, DEPTH_LOG2+1: stored word count.

## Operation
- Storage: pointers are DEPTH_LOG2+1 bits; the extra MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the pointers differ only in the MSB.
  - Pointer wrap is natural modulo-2^(DEPTH_LOG2+1) arithmetic.
- States:
  - **CLOSED**: pointers held at 0. `empty`=1, `eof`=0, `src_full_w`=1. All writes and `src_eof_w` are ignored.
  - **OPEN**: normal streaming.
  - **DRAIN**: EOF requested. Further writes are dropped and `src_full_w`=1. Reads continue.
  - **EOF**: `eof`=1 and `empty`=1 together.
- Transitions:
  - CLOSED→OPEN when `open`=1.
  - OPEN→DRAIN on `src_eof_w`.
  - DRAIN→EOF when `fill_level_w`=0.
  - Any state→CLOSED when `open`=0. This flushes the FIFO, including mid-DRAIN or mid-read.
  - EOF→CLOSED only on close.
- Write rules:
  - Accepted iff state is OPEN, `src_wren_w`=1 and the registered `full`=0.
  - A write while full is rejected even if a read occurs in the same cycle.
- Read rules:
  - When `rden`=1 and `empty`=0, the head word is placed on `user_r_read_32_data_w` one cycle later.
  - `rden` while empty is ignored. The data register holds its value.
- Simultaneous read and write:
  - The fill level is unchanged.
  - When empty, the write is stored and the read is ignored.
- `eof` is never asserted while `empty`=0.

## Timing
- Reset values:
  - data = 0, `empty`=1, `eof`=0.
  - `src_full_w`=1, `src_almost_full_w`=1, `src_open_w`=0.
  - `fill_level_w`=0, state = CLOSED.
- Flags are registered:
  - `empty` deasserts 1 cycle after the first accepted write.
  - `full` asserts in the cycle after the write that fills the FIFO.
- Read latency is 1 cycle (rden edge → data valid).
- Open/close:
  - `open` rise → `src_open_w`=1 one cycle later.
  - `open` fall → CLOSED, `fill`=0 and `empty`=1 one cycle later.
- EOF timing: `eof`=1 one cycle after DRAIN observes `fill`=0.

## Configuration
- Macro: `XB_RD_FIFO_STATS_EN`.
- With the macro defined, two ports are added:
  - `ovf_cnt_w` (out, 16): counts rejected writes while OPEN.
  - `udf_cnt_w` (out, 16): counts `rden` while empty and state ≠ CLOSED.
- Counter behaviour: both saturate at 0xFFFF, clear on reset and on entry to CLOSED, and reset to 0.
- Without the macro, the ports and logic are absent and all other behaviour is identical.

## Structure
- Package `xb_fifo_pkg` holds:
  - the state enum (CLOSED/OPEN/DRAIN/EOF);
  - the `XB_DATA_W`=32 constant;
  - the stats counter width constant, 16.
- Sub-module `xb_sdp_ram`: simple dual-port RAM with one write port and a registered read port, used for storage. The control FSM and pointers stay in the top module.

## Test plan
- Reset then `open`=1, with DEPTH_LOG2=4. Write 0x00000001..0x00000010 (16 words):
  - `src_full_w`=1 after the 16th write;
  - a 17th write is dropped;
  - 16 reads return 1..16 in order, each 1 cycle after `rden`;
  - `empty`=1 after the last read.
- Pointer wrap: 40 words streamed with interleaved reads/writes at fill ≤ 10 → data intact, `fill_level_w` correct every cycle.
- EOF: write 3 words, asserting `src_eof_w` with the 3rd → 3 reads succeed, then `empty`=1 and `eof`=1. Writes in DRAIN are dropped.
- Close mid-stream: 7 words stored, `open`→0 → next cycle `fill`=0, `empty`=1, `eof`=0. Reopening yields an empty stream.
- Simultaneous events:
  - read+write when full: the write is rejected and fill drops to 15;
  - read+write when empty: the write is stored and `empty` deasserts next cycle.
- With `XB_RD_FIFO_STATS_EN`:
  - 5 writes while full → `ovf_cnt_w`=5;
  - 3 `rden` while empty → `udf_cnt_w`=3;
  - close → both counters read 0.
